alu_arbiter: RTL
================

# alu_arbiter

Two-requester, round-robin arbiter and phase sequencer for the shared multi-cycle ALU. Latches one requester's opcode and operands and steps the ALU phase counter so the ALU evaluates exactly once per operation. Captures the ALU result and zero flag, then returns them to the winning requester with a one-cycle done pulse. Sits between the ALU and its two clients: the core execute stage (requester 0) and the game scoring unit (requester 1).

## Interface
- Width, 32, datapath width; matches the ALU `Width`.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  operation request from requester 0 / 1
- ctrl0 / ctrl1  in  4  ALU control code from requester 0 / 1
- a0 / a1  in  Width  first operand from requester 0 / 1
- b0 / b1  in  Width  second operand from requester 0 / 1
- done0 / done1  out  1  one-cycle completion pulse to requester 0 / 1
- gnt0 / gnt1  out  1  requester 0 / 1 owns the ALU; held from SETUP through DONE
- result  out  Width  registered ALU result of the last completed operation
- zero_out  out  1  registered ALU zero flag of the last completed operation
- err  out  1  last completed operation was illegal and was substituted
- busy  out  1  high in every state except IDLE
- alu_counter  out  3  drives the ALU `counter` input
- alu_control  out  4  drives the ALU `Control` input
- alu_a1 / alu_a2  out  Width  drive the ALU `A1` / `A2` inputs
- alu_out  in  Width  ALU `ALUOut`
- alu_zero  in  1  ALU `zero`

## Operation
- FSM states: IDLE, SETUP, EXEC, CAPTURE, DONE. `alu_counter` is 0, 1, 2, 3, 4 in those states respectively.
- IDLE to SETUP when any unmasked request is present. Otherwise stay in IDLE.
- SETUP to EXEC to CAPTURE to DONE, unconditionally, one cycle each.
- DONE to SETUP if an unmasked request is present. Otherwise DONE to IDLE.
- Arbitration runs in IDLE and DONE.
  - One request present: that requester wins.
  - Both present: the requester not granted last wins, using a `last_grant` register.
- Masking: in DONE, the request of the requester currently being completed is ignored. This prevents double issue while the requester drops `req` after seeing `done`.
- At grant (the edge entering SETUP):
  - ctrl/a/b of the winner are latched into `alu_control`, `alu_a1` and `alu_a2`.
  - These outputs stay stable until the next grant.
  - The requester may change its inputs or drop `req` after the grant.
- Illegal substitution, decided at grant:
  - Triggers: ctrl = 4'b1100, or ctrl is 4'b1011 or 4'b1101 with b = 0.
  - Action: `alu_control` is latched as 4'b1001 (ALU produces 0), and a pending-error bit is set.
- CAPTURE edge:
  - `result` <= `alu_out` and `zero_out` <= `alu_zero`.
  - `err` <= the pending-error bit.
- DONE: `done` of the granted requester is high for exactly one cycle, and `gnt` is still high.
- `result`, `zero_out` and `err` hold their values until the next CAPTURE.
- `alu_counter` passes through the value 2 exactly once per operation, so the ALU evaluates exactly once.

## Timing
- Reset values:
  - FSM in IDLE, `alu_counter` = 0, `alu_control` = 0, `alu_a1` = `alu_a2` = 0.
  - `result` = 0, `zero_out` = 0, `err` = 0.
  - `done0` = `done1` = 0, `gnt0` = `gnt1` = 0, `busy` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
- Latency: `req` sampled high in IDLE at cycle t gives SETUP at t+1, EXEC at t+2, CAPTURE at t+3, DONE at t+4. `done` is high during cycle t+4.
- Throughput:
  - One operation per 4 cycles when requests are back to back (DONE to SETUP).
  - One operation per 5 cycles from idle.
- Simultaneous `req0` and `req1` in IDLE: the winner is decided by `last_grant`. The loser is served next, starting SETUP right after the winner's DONE.
- `req` that rises during SETUP, EXEC or CAPTURE is only sampled at the next DONE.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at their reset values.
  - No `done` is issued for the aborted operation.
- Outputs are registered; there is no combinational path from `req` to any output.

## Test plan
- Single op: `req0`=1, ctrl0=4'b0010, a0=5, b0=7 at cycle t. `alu_counter` steps 1,2,3,4 over t+1..t+4. `done0`=1 at t+4 with `result`=12, `zero_out`=0, `err`=0. Then IDLE at t+5.
- Tie and fairness:
  - `req0` and `req1` both held from reset. Grants alternate 0,1,0,1, with `done` every 4 cycles.
  - `gnt0` and `gnt1` are never high together.
- Masking: `req0` held high through its DONE with `req1`=0. Returns to IDLE with no second issue. Re-raising `req0` one cycle later starts a new op.
- Illegal:
  - ctrl0=4'b1101, b0=0: `result`=0, `err`=1, `done0` at t+4.
  - Follow with ctrl0=4'b1111, a0=b0=9: `result`=1, `err`=0.
- Operand latching: change a0 and b0 during EXEC. `result` reflects the values present at grant.
- Reset mid-op: assert `reset` during EXEC. Next cycle: `alu_counter`=0, `busy`=0, no `done`. `result` = 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and phase sequencer for the shared multi-cycle ALU.
// Latches the winner's operation, walks the ALU phase counter once, returns result and done.
module alu_arbiter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       ctrl0,
  input  logic [3:0]       ctrl1,
  input  logic [Width-1:0] a0,
  input  logic [Width-1:0] a1,
  input  logic [Width-1:0] b0,
  input  logic [Width-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [Width-1:0] result,
  output logic             zero_out,
  output logic             err,
  output logic             busy,
  output logic [2:0]       alu_counter,
  output logic [3:0]       alu_control,
  output logic [Width-1:0] alu_a1,
  output logic [Width-1:0] alu_a2,
  input  logic [Width-1:0] alu_out,
  input  logic             alu_zero
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    EXEC    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] CtrlZero = 4'b1001;
  localparam logic [3:0] CtrlBad  = 4'b1100;
  localparam logic [3:0] CtrlDiv  = 4'b1011;
  localparam logic [3:0] CtrlMod  = 4'b1101;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [Width-1:0] opa_q, opa_d;
  logic [Width-1:0] opb_q, opb_d;
  logic             perr_q, perr_d;
  logic [Width-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

  logic             vreq0, vreq1;
  logic             arb_en, grant, winner;
  logic [3:0]       win_ctrl;
  logic [Width-1:0] win_a, win_b;
  logic             win_illegal;

  // In DONE the requester being completed is masked so its still-high req cannot re-issue.
  always_comb begin
    vreq0       = req0 && !(state_q == DONE && !owner_q);
    vreq1       = req1 && !(state_q == DONE && owner_q);
    arb_en      = (state_q == IDLE) || (state_q == DONE);
    grant       = arb_en && (vreq0 || vreq1);
    winner      = (vreq0 && vreq1) ? ~last_grant_q : vreq1;
    win_ctrl    = winner ? ctrl1 : ctrl0;
    win_a       = winner ? a1 : a0;
    win_b       = winner ? b1 : b0;
    win_illegal = (win_ctrl == CtrlBad) ||
                  (((win_ctrl == CtrlDiv) || (win_ctrl == CtrlMod)) && (win_b == '0));
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ctrl_d       = ctrl_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    perr_d       = perr_q;
    result_d     = result_q;
    zero_d       = zero_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (grant) begin
          state_d      = SETUP;
          owner_d      = winner;
          last_grant_d = winner;
          ctrl_d       = win_illegal ? CtrlZero : win_ctrl;
          opa_d        = win_a;
          opb_d        = win_b;
          perr_d       = win_illegal;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:   state_d = EXEC;
      EXEC:    state_d = CAPTURE;
      CAPTURE: begin
        state_d  = DONE;
        result_d = alu_out;
        zero_d   = alu_zero;
        err_d    = perr_q;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from next-state so nothing combinational reaches a port.
    cnt_d   = state_d;
    busy_d  = (state_d != IDLE);
    gnt0_d  = busy_d && !owner_d;
    gnt1_d  = busy_d && owner_d;
    done0_d = (state_d == DONE) && !owner_d;
    done1_d = (state_d == DONE) && owner_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ctrl_q       <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      perr_q       <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ctrl_q       <= ctrl_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      perr_q       <= perr_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign result      = result_q;
  assign zero_out    = zero_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign alu_counter = cnt_q;
  assign alu_control = ctrl_q;
  assign alu_a1      = opa_q;
  assign alu_a2      = opb_q;

endmodule
